// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit: operation codes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SRL  = 2'b00,
    SHIFT_SLL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_PASS = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_seq_unit_if.sv
// Request/response bundle for shift_seq_unit; the requester holds the master modport.
interface shift_seq_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  localparam int unsigned SW = $clog2(XLEN);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [SW-1:0]   shamt;
  // Named op_type because "type" is a reserved word.
  logic [1:0]      op_type;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] r;
  logic            busy;

  modport master (
    output in_valid, a, shamt, op_type, out_ready,
    input  in_ready, out_valid, r, busy
  );

  modport slave (
    input  in_valid, a, shamt, op_type, out_ready,
    output in_ready, out_valid, r, busy
  );

endinterface

// File: rtl/shift_step.sv
// Combinational partial shift of the accumulator by k (0..STEP) bits for one operation.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 1,
  localparam int unsigned KW  = $clog2(STEP + 1)
) (
  input  logic [XLEN-1:0] acc_i,
  input  logic [KW-1:0]   k_i,
  input  shift_op_e       op_i,
  output logic [XLEN-1:0] acc_o
);

  always_comb begin
    acc_o = acc_i;
    unique case (op_i)
      SHIFT_SRL:  acc_o = acc_i >> k_i;
      SHIFT_SLL:  acc_o = acc_i << k_i;
      SHIFT_SRA:  acc_o = $unsigned($signed(acc_i) >>> k_i);
      SHIFT_PASS: acc_o = acc_i;
      default:    acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Iterative shifter: shifts up to STEP bits per cycle and returns the result via valid/ready.
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 1
) (
  input logic               clk,
  input logic               rst_n,
  shift_seq_unit_if.slave   bus
);

  localparam int unsigned SW = $clog2(XLEN);
  localparam int unsigned KW = $clog2(STEP + 1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  shift_op_e       op_q, op_d;

  logic [KW-1:0]   k;
  logic [XLEN-1:0] acc_step;

  assign k = (cnt_q < SW'(STEP)) ? cnt_q[KW-1:0] : KW'(STEP);

  shift_step #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_step (
    .acc_i (acc_q),
    .k_i   (k),
    .op_i  (op_q),
    .acc_o (acc_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= SHIFT_SRL;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = (bus.shamt == '0 || shift_op_e'(bus.op_type) == SHIFT_PASS) ? S_DONE
                                                                                 : S_SHIFT;
        end
      end
      // Leave on the same edge that drains the last bits, not one cycle later.
      S_SHIFT: if (cnt_q <= SW'(STEP)) state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    if (state_q == S_IDLE && bus.in_valid) begin
      acc_d = bus.a;
      cnt_d = bus.shamt;
      op_d  = shift_op_e'(bus.op_type);
    end else if (state_q == S_SHIFT && cnt_q != '0) begin
      acc_d = acc_step;
      cnt_d = cnt_q - SW'(k);
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
    bus.busy      = (state_q != S_IDLE);
    bus.r         = acc_q;
  end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Drives a STEP=1 and a STEP=4 shift unit with identical requests and checks both
// against an arithmetic reference model.
module tb_shift_seq_unit;

  localparam int unsigned XLEN = 32;

  logic clk;
  logic rst_n;

  shift_seq_unit_if #(.XLEN(XLEN)) bus1 ();
  shift_seq_unit_if #(.XLEN(XLEN)) bus4 ();

  shift_seq_unit #(.XLEN(XLEN), .STEP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  shift_seq_unit #(.XLEN(XLEN), .STEP(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    int          sh;
    logic [1:0]  t;
    logic [31:0] exp_r;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift defined by division / multiplication by powers of two.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int sh,
                                            input logic [1:0] t);
    longint unsigned ua;
    longint          sa;
    longint          p;
    int              si;
    ua = {32'd0, a};
    si = a;
    sa = si;
    p  = longint'(1) << sh;
    case (t)
      2'b00:   return 32'(ua / p);
      2'b01:   return 32'((ua * p) % (64'd1 << 32));
      2'b10:   return (sa >= 0) ? 32'(sa / p) : 32'((sa - (p - 1)) / p);
      default: return a;
    endcase
  endfunction

  function automatic int ref_lat(input int sh, input logic [1:0] t, input int step);
    if (sh == 0 || t == 2'b11) return 1;
    return 1 + (sh + step - 1) / step;
  endfunction

  task automatic set_req(input logic v, input logic [31:0] a, input int sh, input logic [1:0] t);
    bus1.in_valid = v;  bus1.a = a;  bus1.shamt = 5'(sh);  bus1.op_type = t;
    bus4.in_valid = v;  bus4.a = a;  bus4.shamt = 5'(sh);  bus4.op_type = t;
  endtask

  task automatic set_oready(input logic v);
    bus1.out_ready = v;
    bus4.out_ready = v;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rst in_ready1"}, 64'(bus1.in_ready), 64'd1);
    chk({tag, " rst out_valid1"}, 64'(bus1.out_valid), 64'd0);
    chk({tag, " rst busy1"}, 64'(bus1.busy), 64'd0);
    chk({tag, " rst r1"}, 64'(bus1.r), 64'd0);
    chk({tag, " rst in_ready4"}, 64'(bus4.in_ready), 64'd1);
    chk({tag, " rst out_valid4"}, 64'(bus4.out_valid), 64'd0);
    chk({tag, " rst busy4"}, 64'(bus4.busy), 64'd0);
    chk({tag, " rst r4"}, 64'(bus4.r), 64'd0);
  endtask

  // One request on both units; called at posedge+1 with both idle.
  task automatic run_op(input string tag, input logic [31:0] a, input int sh,
                        input logic [1:0] t, input logic [31:0] exp_r, input int hold);
    int lat1, lat4;
    logic [31:0] r1s, r4s;
    lat1 = 0;
    lat4 = 0;
    chk({tag, " in_ready1"}, 64'(bus1.in_ready), 64'd1);
    chk({tag, " in_ready4"}, 64'(bus4.in_ready), 64'd1);
    set_req(1'b1, a, sh, t);
    tick();
    set_req(1'b0, $urandom, int'($urandom_range(0, 31)), 2'($urandom));
    chk({tag, " busy1"}, 64'(bus1.busy), 64'd1);
    chk({tag, " busy4"}, 64'(bus4.busy), 64'd1);
    for (int c = 1; c <= 40; c++) begin
      if (lat1 == 0 && bus1.out_valid) lat1 = c;
      if (lat4 == 0 && bus4.out_valid) lat4 = c;
      if (lat1 != 0 && lat4 != 0) break;
      tick();
    end
    chk({tag, " lat1"}, 64'(lat1), 64'(ref_lat(sh, t, 1)));
    chk({tag, " lat4"}, 64'(lat4), 64'(ref_lat(sh, t, 4)));
    chk({tag, " r1"}, 64'(bus1.r), 64'(exp_r));
    chk({tag, " r4"}, 64'(bus4.r), 64'(exp_r));
    r1s = bus1.r;
    r4s = bus4.r;
    // Stalled consumer plus a junk request that must be ignored.
    for (int i = 0; i < hold; i++) begin
      set_req(1'b1, ~a, (sh + 1) % 32, ~t);
      tick();
      chk({tag, " hold r1"}, 64'(bus1.r), 64'(r1s));
      chk({tag, " hold r4"}, 64'(bus4.r), 64'(r4s));
      chk({tag, " hold ov"}, 64'({bus1.out_valid, bus4.out_valid}), 64'd3);
      chk({tag, " hold ir"}, 64'({bus1.in_ready, bus4.in_ready}), 64'd0);
    end
    set_req(1'b0, '0, 0, 2'b00);
    set_oready(1'b1);
    tick();
    set_oready(1'b0);
    chk({tag, " handoff ov"}, 64'({bus1.out_valid, bus4.out_valid}), 64'd0);
    chk({tag, " handoff ir"}, 64'({bus1.in_ready, bus4.in_ready}), 64'd3);
  endtask

  initial begin
    vecs[0]  = '{32'h8000_0000, 4,  2'b10, 32'hF800_0000};
    vecs[1]  = '{32'hF000_0000, 31, 2'b00, 32'h0000_0001};
    vecs[2]  = '{32'h0000_0001, 31, 2'b01, 32'h8000_0000};
    vecs[3]  = '{32'h1234_5678, 0,  2'b00, 32'h1234_5678};
    vecs[4]  = '{32'hABCD_EF01, 0,  2'b01, 32'hABCD_EF01};
    vecs[5]  = '{32'h8000_0001, 0,  2'b10, 32'h8000_0001};
    vecs[6]  = '{32'h1234_5678, 9,  2'b11, 32'h1234_5678};
    vecs[7]  = '{32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF};
    vecs[8]  = '{32'h7FFF_FFFF, 31, 2'b10, 32'h0000_0000};
    vecs[9]  = '{32'hFFFF_FFFF, 1,  2'b00, 32'h7FFF_FFFF};
    vecs[10] = '{32'h1234_5678, 4,  2'b01, 32'h2345_6780};
    vecs[11] = '{32'hC000_0000, 3,  2'b10, 32'hF800_0000};

    rst_n = 1'b0;
    set_req(1'b0, '0, 0, 2'b00);
    set_oready(1'b0);
    #1;
    chk_reset_outputs("init");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].sh, vecs[i].t, vecs[i].exp_r,
             (i == 0) ? 10 : 0);
    end

    // Abort in the middle of a shift.
    set_req(1'b1, 32'h8765_4321, 20, 2'b10);
    tick();
    set_req(1'b0, '0, 0, 2'b00);
    repeat (3) tick();
    chk("abort busy before", 64'({bus1.busy, bus4.busy}), 64'd3);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus1.out_valid || bus4.out_valid || bus1.busy || bus4.busy) begin
        chk("abort stale", 64'({bus1.out_valid, bus4.out_valid, bus1.busy, bus4.busy}), 64'd0);
        break;
      end
    end
    run_op("after abort", 32'h8000_0000, 4, 2'b10, 32'hF800_0000, 1);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] ra;
      int          rs;
      logic [1:0]  rt;
      ra = $urandom;
      rs = int'($urandom_range(0, 31));
      rt = 2'($urandom);
      run_op($sformatf("rnd%0d", n), ra, rs, rt, ref_shift(ra, rs, rt),
             int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
